serial_sub_nbits: RTL

SERIAL_SUB_NBITS -- requirements
Module: serial_sub_nbits

---
 rtl/serial_sub_nbits.sv | 98 +++++++++
 1 files changed

// File: rtl/serial_sub_nbits.sv
// Bit-serial unsigned subtractor: a - b processed LSB first, one bit pair per clock.
// Operands are captured on an accepted start; diff/borrow update only when a result completes.
module serial_sub_nbits #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d_c;
  logic             br_next_c;
  logic             last_c;
  logic [WIDTH-1:0] res_next_c;

  // One full-subtractor bit slice plus the result shift toward diff[0].
  always_comb begin
    d_c        = a_sr[0] ^ b_sr[0] ^ br;
    br_next_c  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    last_c     = (cnt == CW'(WIDTH - 1));
    res_next_c = WIDTH'({d_c, res_sr} >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next_c;
          br     <= br_next_c;
          cnt    <= cnt + CW'(1);
          // Last bit: publish the finished result directly from the slice outputs.
          if (last_c) begin
            diff   <= res_next_c;
            borrow <= br_next_c;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
